// File: rtl/exception_ctrl_cp0.sv
// CP0 exception responder: overflow / undefined-opcode trap entry,
// ERET return, EPC/Cause/EXL bookkeeping and MFC0 read port.
module exception_ctrl_cp0 #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040,
    parameter logic [4:0]  CODE_OVF     = 5'd12,
    parameter logic [4:0]  CODE_RI      = 5'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        overflow,
    input  logic        undef_ID,
    input  logic        eret_ID,
    input  logic [31:0] PC_EX,
    input  logic [31:0] PC_ID,
    input  logic [4:0]  cp0_rd_sel,
    output logic [31:0] cp0_rd_data,
    output logic        Exception,
    output logic        IF_Flush,
    output logic        ID_Flush,
    output logic        EX_Flush,
    output logic        PCRedirect,
    output logic [31:0] RedirectAddr,
    output logic [31:0] EPC,
    output logic [31:0] Cause,
    output logic        EXL
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  code_q, code_d;
    logic        nest_q, nest_d;

    // CP0 state registers; reset is asynchronous so a mid-handler reset
    // drops straight back to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            epc_q   <= 32'h0;
            code_q  <= 5'd0;
            nest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            code_q  <= code_d;
            nest_q  <= nest_d;
        end
    end

    // Request arbitration: overflow (older, in EX) beats undef (in ID);
    // in HANDLER requests are masked but leave the NEST mark.
    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        code_d       = code_q;
        nest_d       = nest_q;
        Exception    = 1'b0;
        IF_Flush     = 1'b0;
        ID_Flush     = 1'b0;
        EX_Flush     = 1'b0;
        PCRedirect   = 1'b0;
        RedirectAddr = HANDLER_ADDR;
        case (state_q)
            RUN: begin
                if (overflow) begin
                    Exception  = 1'b1;
                    IF_Flush   = 1'b1;
                    ID_Flush   = 1'b1;
                    EX_Flush   = 1'b1;
                    PCRedirect = 1'b1;
                    epc_d      = PC_EX;
                    code_d     = CODE_OVF;
                    nest_d     = 1'b0;
                    state_d    = HANDLER;
                end else if (undef_ID) begin
                    Exception  = 1'b1;
                    IF_Flush   = 1'b1;
                    ID_Flush   = 1'b1;
                    PCRedirect = 1'b1;
                    epc_d      = PC_ID;
                    code_d     = CODE_RI;
                    nest_d     = 1'b0;
                    state_d    = HANDLER;
                end
            end
            HANDLER: begin
                if (overflow || undef_ID) begin
                    nest_d = 1'b1;
                end
                if (eret_ID) begin
                    PCRedirect   = 1'b1;
                    RedirectAddr = epc_q;
                    IF_Flush     = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign EPC   = epc_q;
    assign Cause = {25'b0, code_q, 1'b0, nest_q};
    assign EXL   = (state_q == HANDLER);

    // MFC0 read mux over the live register values.
    always_comb begin
        cp0_rd_data = 32'h0;
        case (cp0_rd_sel)
            5'd12:   cp0_rd_data = {31'b0, EXL};
            5'd13:   cp0_rd_data = Cause;
            5'd14:   cp0_rd_data = EPC;
            default: cp0_rd_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl_cp0.sv
// Directed bench for exception_ctrl_cp0: trap entry, priority,
// masking/NEST, ERET return, MFC0 reads and asynchronous reset.
module tb_exception_ctrl_cp0;

    logic        clk;
    logic        rst;
    logic        overflow;
    logic        undef_ID;
    logic        eret_ID;
    logic [31:0] PC_EX;
    logic [31:0] PC_ID;
    logic [4:0]  cp0_rd_sel;
    logic [31:0] cp0_rd_data;
    logic        Exception;
    logic        IF_Flush;
    logic        ID_Flush;
    logic        EX_Flush;
    logic        PCRedirect;
    logic [31:0] RedirectAddr;
    logic [31:0] EPC;
    logic [31:0] Cause;
    logic        EXL;

    int total;
    int bad;

    exception_ctrl_cp0 dut (
        .clk         (clk),
        .rst         (rst),
        .overflow    (overflow),
        .undef_ID    (undef_ID),
        .eret_ID     (eret_ID),
        .PC_EX       (PC_EX),
        .PC_ID       (PC_ID),
        .cp0_rd_sel  (cp0_rd_sel),
        .cp0_rd_data (cp0_rd_data),
        .Exception   (Exception),
        .IF_Flush    (IF_Flush),
        .ID_Flush    (ID_Flush),
        .EX_Flush    (EX_Flush),
        .PCRedirect  (PCRedirect),
        .RedirectAddr(RedirectAddr),
        .EPC         (EPC),
        .Cause       (Cause),
        .EXL         (EXL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        overflow = 1'b0;
        undef_ID = 1'b0;
        eret_ID  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        PC_EX      = 32'h0;
        PC_ID      = 32'h0;
        cp0_rd_sel = 5'd14;
        rst        = 1'b0;
        tick();
        tick();
        total++;
        if ({EPC, Cause, EXL} !== {32'h0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_regs: got EPC=%h Cause=%h EXL=%b want 0/0/0",
                     EPC, Cause, EXL);
        end
        total++;
        if ({Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flush: got %b want 00000",
                     {Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect});
        end
        total++;
        if (RedirectAddr !== 32'h40) begin
            bad++;
            $display("FAIL reset_raddr: got %h want 00000040", RedirectAddr);
        end
        rst = 1'b1;
        tick();
        total++;
        if (cp0_rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd_epc: got %h want 0", cp0_rd_data);
        end
    endtask

    task automatic test_overflow();
        PC_EX    = 32'h14;
        overflow = 1'b1;
        #1;
        total++;
        if ({Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect} !== 5'b11111) begin
            bad++;
            $display("FAIL ovf_flush: got %b want 11111",
                     {Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect});
        end
        total++;
        if (RedirectAddr !== 32'h40) begin
            bad++;
            $display("FAIL ovf_raddr: got %h want 00000040", RedirectAddr);
        end
        total++;
        if (EXL !== 1'b0) begin
            bad++;
            $display("FAIL ovf_exl_pre: got %b want 0", EXL);
        end
        tick();
        idle();
        #1;
        total++;
        if ({EPC, Cause, EXL} !== {32'h14, 32'h30, 1'b1}) begin
            bad++;
            $display("FAIL ovf_regs: got EPC=%h Cause=%h EXL=%b want 14/30/1",
                     EPC, Cause, EXL);
        end
        cp0_rd_sel = 5'd12;
        #1;
        total++;
        if (cp0_rd_data !== 32'h1) begin
            bad++;
            $display("FAIL ovf_rd_status: got %h want 1", cp0_rd_data);
        end
    endtask

    task automatic test_handler();
        overflow = 1'b1;
        #1;
        total++;
        if ({Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect} !== 5'b0) begin
            bad++;
            $display("FAIL mask_flush: got %b want 00000",
                     {Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect});
        end
        tick();
        idle();
        #1;
        total++;
        if ({EPC, Cause, EXL} !== {32'h14, 32'h31, 1'b1}) begin
            bad++;
            $display("FAIL mask_regs: got EPC=%h Cause=%h EXL=%b want 14/31/1",
                     EPC, Cause, EXL);
        end
        eret_ID = 1'b1;
        #1;
        total++;
        if ({Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect} !== 5'b01001) begin
            bad++;
            $display("FAIL eret_flush: got %b want 01001",
                     {Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect});
        end
        total++;
        if (RedirectAddr !== 32'h14) begin
            bad++;
            $display("FAIL eret_raddr: got %h want 00000014", RedirectAddr);
        end
        tick();
        #1;
        total++;
        if ({EPC, Cause, EXL} !== {32'h14, 32'h31, 1'b0}) begin
            bad++;
            $display("FAIL eret_regs: got EPC=%h Cause=%h EXL=%b want 14/31/0",
                     EPC, Cause, EXL);
        end
        total++;
        if ({PCRedirect, IF_Flush, Exception} !== 3'b000) begin
            bad++;
            $display("FAIL eret_run_ignored: got %b want 000",
                     {PCRedirect, IF_Flush, Exception});
        end
        tick();
        idle();
        #1;
        total++;
        if ({EPC, Cause, EXL} !== {32'h14, 32'h31, 1'b0}) begin
            bad++;
            $display("FAIL eret_run_regs: got EPC=%h Cause=%h EXL=%b want 14/31/0",
                     EPC, Cause, EXL);
        end
    endtask

    task automatic test_undef();
        PC_ID    = 32'h20;
        undef_ID = 1'b1;
        #1;
        total++;
        if ({Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect} !== 5'b11101) begin
            bad++;
            $display("FAIL undef_flush: got %b want 11101",
                     {Exception, IF_Flush, ID_Flush, EX_Flush, PCRedirect});
        end
        tick();
        idle();
        cp0_rd_sel = 5'd13;
        #1;
        total++;
        if ({EPC, Cause, EXL} !== {32'h20, 32'h28, 1'b1}) begin
            bad++;
            $display("FAIL undef_regs: got EPC=%h Cause=%h EXL=%b want 20/28/1",
                     EPC, Cause, EXL);
        end
        total++;
        if (cp0_rd_data !== 32'h28) begin
            bad++;
            $display("FAIL undef_rd_cause: got %h want 28", cp0_rd_data);
        end
        eret_ID = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_priority();
        PC_EX    = 32'h8;
        PC_ID    = 32'hC;
        overflow = 1'b1;
        undef_ID = 1'b1;
        #1;
        total++;
        if (EX_Flush !== 1'b1) begin
            bad++;
            $display("FAIL prio_exflush: got %b want 1", EX_Flush);
        end
        tick();
        idle();
        #1;
        total++;
        if ({EPC, Cause, EXL} !== {32'h8, 32'h30, 1'b1}) begin
            bad++;
            $display("FAIL prio_regs: got EPC=%h Cause=%h EXL=%b want 8/30/1",
                     EPC, Cause, EXL);
        end
    endtask

    task automatic test_eret_masked();
        eret_ID  = 1'b1;
        undef_ID = 1'b1;
        #1;
        total++;
        if ({PCRedirect, RedirectAddr, Exception} !== {1'b1, 32'h8, 1'b0}) begin
            bad++;
            $display("FAIL eretm_out: got redir=%b addr=%h exc=%b want 1/8/0",
                     PCRedirect, RedirectAddr, Exception);
        end
        tick();
        idle();
        cp0_rd_sel = 5'd5;
        #1;
        total++;
        if ({EPC, Cause, EXL} !== {32'h8, 32'h31, 1'b0}) begin
            bad++;
            $display("FAIL eretm_regs: got EPC=%h Cause=%h EXL=%b want 8/31/0",
                     EPC, Cause, EXL);
        end
        total++;
        if (cp0_rd_data !== 32'h0) begin
            bad++;
            $display("FAIL rd_other_sel: got %h want 0", cp0_rd_data);
        end
    endtask

    task automatic test_async_reset();
        PC_EX    = 32'h14;
        overflow = 1'b1;
        tick();
        idle();
        #1;
        total++;
        if (EXL !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: got EXL=%b want 1", EXL);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({EPC, Cause, EXL} !== {32'h0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL areset_regs: got EPC=%h Cause=%h EXL=%b want 0/0/0",
                     EPC, Cause, EXL);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_overflow();
        test_handler();
        test_undef();
        test_priority();
        test_eret_masked();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
